// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the two-port data-memory
//               arbiter: state encoding, default geometry, port indices.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

   // Default geometry
   localparam int c_def_aw        = 30;
   localparam int c_def_dw        = 32;
   localparam int c_def_max_burst = 4;

   // Port indices as stored in last_grant
   localparam logic c_port0 = 1'b0;
   localparam logic c_port1 = 1'b1;

   // Arbiter state encoding
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } arb_state_e;

   // Burst counter width; never below one bit so MAX_BURST=1 still builds
   function automatic int ctr_width(input int max_burst);
      int w;
      w = $clog2(max_burst);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_burst_ctr
// Description : Burst counter for the arbiter. Counts accesses of the current
//               grant, clears on request, saturates at MAX_BURST-1 and flags
//               the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_burst_ctr
   import dmem_arb_pkg::*;
#(
   parameter int MAX_BURST = c_def_max_burst,
   parameter int CW        = ctr_width(MAX_BURST)
) (
   input  logic clk,
   input  logic areset,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam logic [CW-1:0] c_last = CW'(MAX_BURST - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign tc = (count_q == c_last);

   // Next count: clear wins, increment holds once the terminal value is hit
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !tc) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter in front of a single-port data memory with
//               asynchronous read. Port 0 is the CPU load/store path, port 1
//               the DMA/loader. Grants alternate on contention and a port may
//               hold the memory for at most MAX_BURST accesses while the
//               other one waits.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = c_def_aw,
   parameter int DW        = c_def_dw,
   parameter int MAX_BURST = c_def_max_burst
) (
   input  logic          clk,
   input  logic          areset,
   // requester 0 (CPU)
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   // requester 1 (DMA/loader)
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   // shared return data and CPU stall
   output logic [DW-1:0] rdata,
   output logic          stall0,
   // data memory
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       last_grant_q;
   logic       last_grant_d;

   logic       w_ctr_clr;
   logic       w_ctr_inc;
   logic       w_ctr_tc;

   arb_burst_ctr #(
      .MAX_BURST (MAX_BURST)
   ) u_ctr (
      .clk    (clk),
      .areset (areset),
      .clr    (w_ctr_clr),
      .inc    (w_ctr_inc),
      .tc     (w_ctr_tc)
   );

   // Every completed access advances the burst counter
   assign w_ctr_inc = ack0 | ack1;

   // The CPU stalls whenever it asks and is not served this cycle
   assign stall0 = req0 & ~ack0;

   // Memory-side mux: only the granted, still-requesting port reaches mem_*
   always_comb begin
      ack0      = 1'b0;
      ack1      = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      rdata     = '0;
      case (state_q)
         GNT0: begin
            if (req0) begin
               ack0      = 1'b1;
               mem_addr  = addr0;
               mem_wdata = wdata0;
               mem_we    = we0;
               rdata     = mem_rdata;
            end
         end
         GNT1: begin
            if (req1) begin
               ack1      = 1'b1;
               mem_addr  = addr1;
               mem_wdata = wdata1;
               mem_we    = we1;
               rdata     = mem_rdata;
            end
         end
         default: begin
         end
      endcase
   end

   // Next-state logic: grant choice from IDLE, hand-over on drop or burst end
   always_comb begin
      state_d   = state_q;
      w_ctr_clr = 1'b0;
      case (state_q)
         IDLE: begin
            w_ctr_clr = 1'b1;
            // On contention the port that did not win last time goes first
            if (req0 && (!req1 || (last_grant_q == c_port1))) begin
               state_d = GNT0;
            end else if (req1) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            if (!req0) begin
               w_ctr_clr = 1'b1;
               state_d   = req1 ? GNT1 : IDLE;
            end else if (w_ctr_tc && req1) begin
               w_ctr_clr = 1'b1;
               state_d   = GNT1;
            end
         end
         GNT1: begin
            if (!req1) begin
               w_ctr_clr = 1'b1;
               state_d   = req0 ? GNT0 : IDLE;
            end else if (w_ctr_tc && req0) begin
               w_ctr_clr = 1'b1;
               state_d   = GNT0;
            end
         end
         default: begin
            w_ctr_clr = 1'b1;
            state_d   = IDLE;
         end
      endcase
   end

   // Remember which port was granted most recently, updated on grant entry
   always_comb begin
      last_grant_d = last_grant_q;
      if ((state_d == GNT0) && (state_q != GNT0)) begin
         last_grant_d = c_port0;
      end else if ((state_d == GNT1) && (state_q != GNT1)) begin
         last_grant_d = c_port1;
      end
   end

   // State and fairness registers; reset leaves port 0 as first winner
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q      <= IDLE;
         last_grant_q <= c_port1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A driver feeds per-port
//               transaction queues, a monitor predicts acks with an abstract
//               arbitration model and scoreboards every access against a
//               reference memory. Directed scenarios inspect a cycle trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int AW        = 30;
   localparam int DW        = 32;
   localparam int MAX_BURST = 4;

   typedef struct {
      logic          we;
      logic [7:0]    addr;
      logic [DW-1:0] wdata;
      int            gap;       // idle cycles before presenting
      int            hold_max;  // give up after this many unacked cycles (0 = never)
   } stim_t;

   typedef struct {
      logic          we;
      logic [7:0]    addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct {
      logic          a0;
      logic          a1;
      logic          r0;
      logic          st0;
      logic [DW-1:0] rd;
   } obs_t;

   logic          clk    = 1'b0;
   logic          areset = 1'b0;
   logic          req0   = 1'b0;
   logic          we0    = 1'b0;
   logic [AW-1:0] addr0  = '0;
   logic [DW-1:0] wdata0 = '0;
   logic          req1   = 1'b0;
   logic          we1    = 1'b0;
   logic [AW-1:0] addr1  = '0;
   logic [DW-1:0] wdata1 = '0;
   logic          ack0;
   logic          ack1;
   logic          stall0;
   logic          mem_we;
   logic [DW-1:0] rdata;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] mem     [0:255];
   logic [DW-1:0] ref_mem [0:255];

   stim_t stim_q [2][$];
   txn_t  exp_q  [2][$];
   obs_t  trace  [$];

   logic  ack_seen [2];
   logic  busy     [2];
   stim_t cur      [2];
   int    held     [2];

   // reference arbitration: who owns the memory, accesses done, last winner
   int owner = -1;
   int run   = 0;
   int last  = 1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .AW        (AW),
      .DW        (DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .areset    (areset),
      .req0      (req0),
      .we0       (we0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .ack0      (ack0),
      .req1      (req1),
      .we1       (we1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .ack1      (ack1),
      .rdata     (rdata),
      .stall0    (stall0),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   // data memory with asynchronous read
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
   end

   function automatic logic [DW-1:0] init_val(input logic [7:0] a);
      return {16'hC0DE, 8'h00, a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic grant_to(input int p);
      owner = p;
      last  = p;
      run   = 0;
   endtask

   // Arbitration rules applied to the requests seen this cycle, giving the
   // owner for the cycle after the next edge.
   task automatic model_step(input logic r0, input logic r1);
      logic r [2];
      r[0] = r0;
      r[1] = r1;
      if (owner < 0) begin
         if (r0 && r1)  grant_to(1 - last);
         else if (r0)   grant_to(0);
         else if (r1)   grant_to(1);
      end else if (!r[owner]) begin
         if (r[1-owner]) grant_to(1 - owner);
         else            owner = -1;
      end else begin
         run++;
         if (run >= MAX_BURST && r[1-owner]) grant_to(1 - owner);
      end
   endtask

   // Monitor: predict acks, scoreboard completed accesses, record a trace
   initial begin
      logic e0, e1;
      int   n;
      txn_t t;
      obs_t o;
      ack_seen[0] = 1'b0;
      ack_seen[1] = 1'b0;
      forever begin
         @(negedge clk);
         ack_seen[0] = ack0;
         ack_seen[1] = ack1;
         if (!areset) begin
            owner = -1;
            run   = 0;
            last  = 1;
            check("rst_ack0", ack0, 1'b0);
            check("rst_ack1", ack1, 1'b0);
            check("rst_mem_we", mem_we, 1'b0);
            check("rst_mem_addr", mem_addr, '0);
            check("rst_stall0", stall0, req0);
         end else begin
            e0 = (owner == 0) && req0;
            e1 = (owner == 1) && req1;
            check("ack0", ack0, e0);
            check("ack1", ack1, e1);
            check("stall0", stall0, req0 && !e0);
            if (e0 || e1) begin
               n = e0 ? 0 : 1;
               check("sb_pending", exp_q[n].size() > 0, 1'b1);
               if (exp_q[n].size() > 0) begin
                  t = exp_q[n].pop_front();
                  check("mem_addr", mem_addr, t.addr);
                  check("mem_we", mem_we, t.we);
                  check("mem_wdata", mem_wdata, t.wdata);
                  if (t.we) ref_mem[t.addr] = t.wdata;
                  else      check("rdata", rdata, ref_mem[t.addr]);
               end
            end else begin
               check("idle_mem_we", mem_we, 1'b0);
               check("idle_mem_addr", mem_addr, '0);
               check("idle_mem_wdata", mem_wdata, '0);
            end
            o.a0 = ack0; o.a1 = ack1; o.r0 = req0; o.st0 = stall0; o.rd = rdata;
            trace.push_back(o);
            model_step(req0, req1);
         end
      end
   end

   // Driver: one outstanding access per port, held until acked or abandoned
   initial begin
      stim_t s;
      txn_t  t;
      logic  dropped;
      for (int n = 0; n < 2; n++) begin
         busy[n] = 1'b0;
         held[n] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int n = 0; n < 2; n++) begin
            dropped = 1'b0;
            if (!areset) begin
               busy[n] = 1'b0;
               exp_q[n].delete();
            end else begin
               if (busy[n]) begin
                  if (ack_seen[n]) begin
                     busy[n] = 1'b0;
                  end else begin
                     held[n]++;
                     if (cur[n].hold_max > 0 && held[n] >= cur[n].hold_max) begin
                        busy[n] = 1'b0;
                        dropped = 1'b1;
                        void'(exp_q[n].pop_back());
                     end
                  end
               end
               if (!busy[n] && !dropped && stim_q[n].size() > 0) begin
                  s = stim_q[n].pop_front();
                  if (s.gap > 0) begin
                     s.gap--;
                     stim_q[n].push_front(s);
                  end else begin
                     cur[n]  = s;
                     busy[n] = 1'b1;
                     held[n] = 0;
                     t.we = s.we; t.addr = s.addr; t.wdata = s.wdata;
                     exp_q[n].push_back(t);
                  end
               end
            end
         end
         // idle ports carry junk so any leak onto mem_* is visible
         req0   = busy[0];
         we0    = busy[0] ? cur[0].we : 1'($urandom);
         addr0  = busy[0] ? AW'(cur[0].addr) : AW'($urandom);
         wdata0 = busy[0] ? cur[0].wdata : $urandom;
         req1   = busy[1];
         we1    = busy[1] ? cur[1].we : 1'($urandom);
         addr1  = busy[1] ? AW'(cur[1].addr) : AW'($urandom);
         wdata1 = busy[1] ? cur[1].wdata : $urandom;
      end
   end

   task automatic push(input int n, input logic we, input logic [7:0] a,
                       input logic [DW-1:0] d, input int gap, input int hold);
      stim_t s;
      s.we = we; s.addr = a; s.wdata = d; s.gap = gap; s.hold_max = hold;
      stim_q[n].push_back(s);
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge clk);
         #2;
         done = (stim_q[0].size() == 0) && (stim_q[1].size() == 0) && !busy[0] && !busy[1];
      end
      check({name, "_drained"}, done, 1'b1);
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2 areset = 1'b0;
      stim_q[0].delete();
      stim_q[1].delete();
      repeat (2) @(posedge clk);
      #2 areset = 1'b1;
      trace.delete();
   endtask

   // wait (bounded) until port p has been acked cnt times in the trace
   task automatic wait_acks(input int p, input int cnt, input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < 200 && seen < cnt; i++) begin
         @(negedge clk);
         #1;
         seen = 0;
         foreach (trace[k]) seen += int'(p == 0 ? trace[k].a0 : trace[k].a1);
      end
      check({name, "_acks_seen"}, seen >= cnt, 1'b1);
   endtask

   function automatic logic obs_bit(input obs_t o, input int which);
      case (which)
         0:       return o.a0;
         1:       return o.a1;
         2:       return o.r0;
         3:       return o.st0;
         4:       return o.a0 | o.a1;
         default: return o.a0 & o.a1;
      endcase
   endfunction

   function automatic int first_idx(input int which);
      foreach (trace[k]) if (obs_bit(trace[k], which)) return k;
      return -1;
   endfunction

   function automatic int last_idx(input int which);
      int r;
      r = -1;
      foreach (trace[k]) if (obs_bit(trace[k], which)) r = k;
      return r;
   endfunction

   function automatic int count_of(input int which);
      int c;
      c = 0;
      foreach (trace[k]) c += int'(obs_bit(trace[k], which));
      return c;
   endfunction

   initial begin
      #800_000;
      $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            fa, fr, fb, la, f, c;
      logic [11:0]   pat0, pat1;
      logic [DW-1:0] wd [8];

      for (int i = 0; i < 256; i++) begin
         mem[i]     = init_val(8'(i));
         ref_mem[i] = init_val(8'(i));
      end

      // reset state
      repeat (2) @(posedge clk);
      #2;
      check("reset_ack0", ack0, 1'b0);
      check("reset_ack1", ack1, 1'b0);
      check("reset_mem_we", mem_we, 1'b0);
      check("reset_mem_wdata", mem_wdata, '0);
      check("reset_rdata", rdata, '0);
      check("reset_stall0", stall0, req0);
      areset = 1'b1;
      trace.delete();

      // single read: one IDLE cycle of stall, then ack with memory data
      push(0, 1'b0, 8'h10, $urandom, 0, 0);
      wait_idle("t1");
      fr = first_idx(2);
      fa = first_idx(0);
      check("t1_grant_latency", fa - fr, 1);
      check("t1_stall_cycles", count_of(3), 1);
      check("t1_rdata", (fa >= 0) ? trace[fa].rd : '0, init_val(8'h10));

      // simultaneous requests after reset: port 0 first, port 1 directly after
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         push(0, 1'b0, 8'(1 + i), $urandom, 0, 0);
         push(1, 1'b0, 8'(4 + i), $urandom, 0, 0);
      end
      wait_idle("t2");
      f = first_idx(4);
      check("t2_first_grant_port0", (f >= 0) ? trace[f].a0 : 1'b0, 1'b1);
      la = last_idx(0);
      fb = first_idx(1);
      // one cycle in GNT0 observing the drop, then straight into GNT1
      check("t2_handover_gap", fb - la, 2);

      // both ports saturated: alternate in bursts of MAX_BURST
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         push(0, 1'($urandom), 8'($urandom_range(0, 15)), $urandom, 0, 0);
         push(1, 1'($urandom), 8'($urandom_range(0, 15)), $urandom, 0, 0);
      end
      wait_idle("t3");
      f = first_idx(4);
      pat0 = '0;
      pat1 = '0;
      if (f >= 0 && f + 11 < trace.size()) begin
         for (int i = 0; i < 12; i++) begin
            pat0 = {pat0[10:0], trace[f+i].a0};
            pat1 = {pat1[10:0], trace[f+i].a1};
         end
      end
      check("t3_ack1_pattern", pat1, 12'b0000_1111_0000);
      check("t3_ack0_pattern", pat0, 12'b1111_0000_1111);

      // port 1 alone, 8 back-to-back writes through a saturated counter
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         wd[i] = $urandom;
         push(1, 1'b1, 8'(i), wd[i], 0, 0);
      end
      wait_idle("t4");
      check("t4_ack1_count", count_of(1), 8);
      check("t4_back_to_back", last_idx(1) - first_idx(1), 7);
      for (int i = 0; i < 8; i++) check($sformatf("t4_mem_%0d", i), mem[i], wd[i]);

      // reset during the second write of a port-1 burst
      apply_reset();
      wd[0] = $urandom;
      wd[1] = $urandom;
      push(1, 1'b1, 8'h20, wd[0], 0, 0);
      push(1, 1'b1, 8'h21, wd[1], 0, 0);
      push(1, 1'b1, 8'h22, $urandom, 0, 0);
      wait_acks(1, 1, "t5");
      @(posedge clk);
      #2;
      check("t5_second_write_live", mem_we, 1'b1);
      areset = 1'b0;
      stim_q[1].delete();
      #1;
      check("t5_abort_mem_we", mem_we, 1'b0);
      check("t5_abort_ack1", ack1, 1'b0);
      check("t5_abort_mem_addr", mem_addr, '0);
      repeat (2) @(posedge clk);
      #2 areset = 1'b1;
      trace.delete();
      check("t5_first_write_done", mem[8'h20], wd[0]);
      check("t5_second_write_blocked", mem[8'h21], init_val(8'h21));
      push(0, 1'b0, 8'h30, $urandom, 0, 0);
      push(1, 1'b0, 8'h31, $urandom, 0, 0);
      wait_idle("t5");
      f = first_idx(4);
      check("t5_port0_first", (f >= 0) ? trace[f].a0 : 1'b0, 1'b1);

      // port 1 arrives during a long port-0 burst
      apply_reset();
      for (int i = 0; i < 10; i++) push(0, 1'b0, 8'($urandom_range(0, 15)), $urandom, 0, 0);
      wait_acks(0, 1, "t6");
      for (int i = 0; i < 3; i++) push(1, 1'b0, 8'($urandom_range(0, 15)), $urandom, 0, 0);
      wait_idle("t6");
      fb = first_idx(1);
      c = 0;
      for (int i = 0; i < fb; i++) c += int'(trace[i].a0);
      check("t6_ack0_before_ack1", c, 4);
      check("t6_never_both", count_of(5), 0);
      check("t6_ack0_total", count_of(0), 10);
      check("t6_ack1_total", count_of(1), 3);

      // random traffic with gaps and occasional abandoned requests
      apply_reset();
      for (int i = 0; i < 150; i++) begin
         for (int n = 0; n < 2; n++) begin
            push(n, 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
         end
      end
      wait_idle("t7");
      check("t7_never_both", count_of(5), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
